// File: rtl/step_dump_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// step_dump_controller: dumps 18 core registers over valid/ready, then pulses
// switchRun for RUN_CYCLES and counts the completed step.       rev 1.0
// ---------------------------------------------------------------------------
module step_dump_controller #(
  parameter int SETTLE_CYCLES = 4,
  parameter int RUN_CYCLES    = 16,
  parameter int COUNT_W       = 16
) (
  input  logic               clkFast,
  input  logic               reset,
  input  logic               start,
  input  logic               auto_mode,
  input  logic               halt,
  input  logic [31:0]        reg_read_data_1,
  input  logic               dump_ready,
  output logic [4:0]         SwitchSelector,
  output logic               switchRun,
  output logic               dump_valid,
  output logic [4:0]         dump_index,
  output logic [31:0]        dump_data,
  output logic [COUNT_W-1:0] step_count,
  output logic               busy,
  output logic               done
);

  localparam int               MAX_CYC     = (SETTLE_CYCLES > RUN_CYCLES) ? SETTLE_CYCLES : RUN_CYCLES;
  localparam int               CNT_W       = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
  localparam logic [4:0]       LAST_SLOT   = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EMIT   = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         slot_q, slot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         sel_q, sel_d;
  logic               run_q, run_d;
  logic               valid_q, valid_d;
  logic [4:0]         idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Scan order: slots 0-7 -> 16-23, 8-15 -> 8-15, 16-17 -> 24-25.
  function automatic logic [4:0] slot_to_idx(input logic [4:0] s);
    if (s < 5'd8)       return s + 5'd16;
    else if (s < 5'd16) return s;
    else                return s + 5'd8;
  endfunction

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    run_d   = run_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          slot_d  = 5'd0;
          cnt_d   = '0;
          sel_d   = slot_to_idx(5'd0);
        end
      end
      S_SELECT: begin
        if (cnt_q == SETTLE_LAST) begin
          data_d  = reg_read_data_1;
          idx_d   = sel_q;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          if (slot_q != LAST_SLOT) begin
            slot_d  = slot_q + 5'd1;
            sel_d   = slot_to_idx(slot_q + 5'd1);
            state_d = S_SELECT;
          end else begin
            run_d   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          run_d   = 1'b0;
          done_d  = 1'b1;
          count_d = count_q + COUNT_W'(1);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // halt only matters here: it stops chaining, never an in-flight step.
        if (auto_mode && !halt) begin
          state_d = S_SELECT;
          slot_d  = 5'd0;
          cnt_d   = '0;
          sel_d   = slot_to_idx(5'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SwitchSelector = sel_q;
  assign switchRun      = run_q;
  assign dump_valid     = valid_q;
  assign dump_index     = idx_q;
  assign dump_data      = data_q;
  assign step_count     = count_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_step_dump_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_step_dump_controller: randomized bench checked against a scan-order and
// cycle-timing reference model of one step.                      rev 1.0
// ---------------------------------------------------------------------------
module tb_step_dump_controller;

  localparam int S        = 4;
  localparam int R        = 16;
  localparam int CW       = 2;
  localparam int STEP_CYC = 18 * (S + 1) + R + 1;

  logic          clkFast = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          auto_mode = 1'b0;
  logic          halt = 1'b0;
  logic          dump_ready = 1'b1;
  logic [31:0]   reg_read_data_1;
  logic [4:0]    SwitchSelector;
  logic          switchRun;
  logic          dump_valid;
  logic [4:0]    dump_index;
  logic [31:0]   dump_data;
  logic [CW-1:0] step_count;
  logic          busy;
  logic          done;

  logic [31:0] regs [32];
  int order [18] = '{16, 17, 18, 19, 20, 21, 22, 23, 8, 9, 10, 11, 12, 13, 14, 15, 24, 25};

  int checks = 0;
  int failures = 0;
  int model_count = 0;

  assign reg_read_data_1 = regs[SwitchSelector];

  step_dump_controller #(
    .SETTLE_CYCLES (S),
    .RUN_CYCLES    (R),
    .COUNT_W       (CW)
  ) dut (
    .clkFast         (clkFast),
    .reset           (reset),
    .start           (start),
    .auto_mode       (auto_mode),
    .halt            (halt),
    .reg_read_data_1 (reg_read_data_1),
    .dump_ready      (dump_ready),
    .SwitchSelector  (SwitchSelector),
    .switchRun       (switchRun),
    .dump_valid      (dump_valid),
    .dump_index      (dump_index),
    .dump_data       (dump_data),
    .step_count      (step_count),
    .busy            (busy),
    .done            (done)
  );

  always #5 clkFast = ~clkFast;

  // Observation log: cycle number, transfers, run cycles and done pulses.
  int            cyc = 0;
  logic [4:0]    tr_idx [$];
  logic [31:0]   tr_dat [$];
  int            tr_cyc [$];
  int            run_cyc [$];
  int            done_cyc [$];
  int            busy_cycles = 0;

  always @(posedge clkFast) cyc <= cyc + 1;

  always @(negedge clkFast) begin
    if (dump_valid && dump_ready) begin
      tr_idx.push_back(dump_index);
      tr_dat.push_back(dump_data);
      tr_cyc.push_back(cyc);
    end
    if (switchRun) run_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  task automatic tick();
    @(posedge clkFast);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_count = 0;
  endtask

  task automatic wait_idle(input int bound, input string what);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL timeout_%s: busy=%0b after %0d cycles, required 0", what, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (SwitchSelector !== 5'd0) begin failures++; $display("FAIL rst_sel: got %0d exp 0", SwitchSelector); end
    checks++; if (switchRun !== 1'b0) begin failures++; $display("FAIL rst_run: got %b exp 0", switchRun); end
    checks++; if (dump_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", dump_valid); end
    checks++; if (dump_index !== 5'd0) begin failures++; $display("FAIL rst_index: got %0d exp 0", dump_index); end
    checks++; if (dump_data !== 32'd0) begin failures++; $display("FAIL rst_data: got %h exp 0", dump_data); end
    checks++; if (step_count !== '0) begin failures++; $display("FAIL rst_count: got %0d exp 0", step_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b exp 0", done); end
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_hold: busy got %b exp 0", busy); end
    model_count = 0;
  endtask

  task automatic test_basic_step();
    int b_tr, b_run, b_done, b_busy, c0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    b_tr = tr_idx.size(); b_run = run_cyc.size(); b_done = done_cyc.size(); b_busy = busy_cycles;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_c1: got %b exp 1", busy); end
    checks++; if (SwitchSelector !== 5'd16) begin failures++; $display("FAIL basic_sel_c1: got %0d exp 16", SwitchSelector); end
    wait_idle(400, "basic");
    model_count = (model_count + 1) % (1 << CW);
    checks++;
    if (tr_idx.size() - b_tr != 18) begin
      failures++; $display("FAIL basic_ntr: got %0d exp 18", tr_idx.size() - b_tr);
    end else begin
      for (int k = 0; k < 18; k++) begin
        checks++;
        if (tr_idx[b_tr+k] !== 5'(order[k]) || tr_dat[b_tr+k] !== 32'h1000 + 32'(order[k]) ||
            tr_cyc[b_tr+k] != c0 + 1 + S + k * (S + 1)) begin
          failures++;
          $display("FAIL basic_tr%0d: got idx=%0d data=%h cyc=%0d exp idx=%0d data=%h cyc=%0d", k,
                   tr_idx[b_tr+k], tr_dat[b_tr+k], tr_cyc[b_tr+k] - c0,
                   order[k], 32'h1000 + order[k], 1 + S + k * (S + 1));
        end
      end
    end
    checks++;
    if (run_cyc.size() - b_run != R || run_cyc[b_run] != c0 + 1 + 18 * (S + 1) ||
        run_cyc[run_cyc.size()-1] != c0 + 18 * (S + 1) + R) begin
      failures++; $display("FAIL basic_run: got n=%0d exp n=%0d starting cycle %0d", run_cyc.size() - b_run, R, 1 + 18 * (S + 1));
    end
    checks++;
    if (done_cyc.size() - b_done != 1 || done_cyc[done_cyc.size()-1] != c0 + STEP_CYC) begin
      failures++; $display("FAIL basic_done: got n=%0d exp 1 at cycle %0d", done_cyc.size() - b_done, STEP_CYC);
    end
    checks++; if (step_count !== CW'(model_count)) begin failures++; $display("FAIL basic_count: got %0d exp %0d", step_count, model_count); end
    checks++; if (busy_cycles - b_busy != STEP_CYC) begin failures++; $display("FAIL basic_busy_len: got %0d exp %0d", busy_cycles - b_busy, STEP_CYC); end
  endtask

  task automatic test_backpressure();
    int b_tr, n;
    logic [31:0] exp_dat [18];
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int k = 0; k < 18; k++) exp_dat[k] = regs[order[k]];
    b_tr = tr_idx.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(SwitchSelector == 5'd18 && !dump_valid) && n < 100) begin tick(); n++; end
    checks++; if (SwitchSelector !== 5'd18) begin failures++; $display("FAIL bp_reach_slot2: sel got %0d exp 18", SwitchSelector); end
    dump_ready = 1'b0;
    n = 0;
    while (!dump_valid && n < 20) begin tick(); n++; end
    checks++; if (dump_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout: got %b exp 1", dump_valid); end
    regs[18] = ~regs[18];
    for (int j = 0; j < 10; j++) begin
      checks++;
      if ({dump_valid, dump_index, SwitchSelector, dump_data} !== {1'b1, 5'd18, 5'd18, exp_dat[2]}) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b idx=%0d sel=%0d data=%h exp v=1 idx=18 sel=18 data=%h",
                 j, dump_valid, dump_index, SwitchSelector, dump_data, exp_dat[2]);
      end
      tick();
    end
    dump_ready = 1'b1;
    wait_idle(400, "backpressure");
    model_count = (model_count + 1) % (1 << CW);
    checks++;
    if (tr_idx.size() - b_tr != 18) begin
      failures++; $display("FAIL bp_ntr: got %0d exp 18", tr_idx.size() - b_tr);
    end else begin
      for (int k = 0; k < 18; k++) begin
        checks++;
        if (tr_idx[b_tr+k] !== 5'(order[k]) || tr_dat[b_tr+k] !== exp_dat[k]) begin
          failures++;
          $display("FAIL bp_tr%0d: got idx=%0d data=%h exp idx=%0d data=%h", k, tr_idx[b_tr+k], tr_dat[b_tr+k], order[k], exp_dat[k]);
        end
      end
    end
    checks++; if (step_count !== CW'(model_count)) begin failures++; $display("FAIL bp_count: got %0d exp %0d", step_count, model_count); end
  endtask

  task automatic test_auto_halt();
    int b_tr, b_run, b_done, b_busy, n;
    do_reset();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    b_tr = tr_idx.size(); b_run = run_cyc.size(); b_done = done_cyc.size(); b_busy = busy_cycles;
    auto_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (tr_idx.size() < b_tr + 2 * 18 + 9 && n < 1000) begin tick(); n++; end
    checks++; if (tr_idx.size() < b_tr + 45) begin failures++; $display("FAIL auto_third_step_timeout: transfers got %0d exp 45", tr_idx.size() - b_tr); end
    halt = 1'b1;
    wait_idle(500, "auto_halt");
    repeat (40) tick();
    model_count = 3;
    checks++; if (done_cyc.size() - b_done != 3) begin failures++; $display("FAIL auto_ndone: got %0d exp 3", done_cyc.size() - b_done); end
    checks++; if (run_cyc.size() - b_run != 3 * R) begin failures++; $display("FAIL auto_nrun: got %0d exp %0d", run_cyc.size() - b_run, 3 * R); end
    checks++; if (busy_cycles - b_busy != 3 * STEP_CYC) begin failures++; $display("FAIL auto_busy_len: got %0d exp %0d", busy_cycles - b_busy, 3 * STEP_CYC); end
    checks++; if (step_count !== CW'(model_count)) begin failures++; $display("FAIL auto_count: got %0d exp %0d", step_count, model_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL auto_idle: busy got %b exp 0", busy); end
    checks++;
    if (tr_idx.size() - b_tr != 54) begin
      failures++; $display("FAIL auto_ntr: got %0d exp 54", tr_idx.size() - b_tr);
    end else begin
      for (int k = 0; k < 54; k++) begin
        if (tr_idx[b_tr+k] !== 5'(order[k%18]) || tr_dat[b_tr+k] !== regs[order[k%18]]) begin
          failures++;
          $display("FAIL auto_tr%0d: got idx=%0d data=%h exp idx=%0d data=%h", k, tr_idx[b_tr+k], tr_dat[b_tr+k], order[k%18], regs[order[k%18]]);
        end
      end
    end
    checks++;
    if (done_cyc.size() - b_done == 3 && (done_cyc[b_done+1] - done_cyc[b_done] != STEP_CYC || done_cyc[b_done+2] - done_cyc[b_done+1] != STEP_CYC)) begin
      failures++; $display("FAIL auto_spacing: got %0d,%0d exp %0d", done_cyc[b_done+1] - done_cyc[b_done], done_cyc[b_done+2] - done_cyc[b_done+1], STEP_CYC);
    end
    auto_mode = 1'b0;
    halt = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int b_tr, b_run, b_done, n;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    b_run = run_cyc.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(switchRun && run_cyc.size() - b_run == 4) && n < 300) begin tick(); n++; end
    checks++; if (switchRun !== 1'b1) begin failures++; $display("FAIL rmr_run5_timeout: switchRun got %b exp 1", switchRun); end
    reset = 1'b0;
    #1;
    checks++; if (switchRun !== 1'b0) begin failures++; $display("FAIL rmr_run_drop: got %b exp 0", switchRun); end
    checks++;
    if ({SwitchSelector, dump_valid, dump_index, dump_data, step_count, busy, done} !== '0) begin
      failures++;
      $display("FAIL rmr_outputs: got sel=%0d v=%b idx=%0d data=%h cnt=%0d busy=%b done=%b exp all 0",
               SwitchSelector, dump_valid, dump_index, dump_data, step_count, busy, done);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_count = 0;
    b_tr = tr_idx.size(); b_run = run_cyc.size(); b_done = done_cyc.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(400, "rmr_restart");
    model_count = 1;
    checks++; if (tr_idx.size() - b_tr != 18) begin failures++; $display("FAIL rmr_ntr: got %0d exp 18", tr_idx.size() - b_tr); end
    checks++; if (run_cyc.size() - b_run != R) begin failures++; $display("FAIL rmr_nrun: got %0d exp %0d", run_cyc.size() - b_run, R); end
    checks++; if (done_cyc.size() - b_done != 1) begin failures++; $display("FAIL rmr_ndone: got %0d exp 1", done_cyc.size() - b_done); end
    checks++; if (step_count !== CW'(model_count)) begin failures++; $display("FAIL rmr_count: got %0d exp %0d", step_count, model_count); end
    checks++;
    if (tr_idx.size() - b_tr == 18 && (tr_idx[b_tr+17] !== 5'd25 || tr_dat[b_tr+17] !== regs[25])) begin
      failures++; $display("FAIL rmr_last_tr: got idx=%0d data=%h exp idx=25 data=%h", tr_idx[b_tr+17], tr_dat[b_tr+17], regs[25]);
    end
  endtask

  task automatic test_ignored_start_wrap();
    int b_all, b_d, b_bc, n;
    do_reset();
    b_all = done_cyc.size();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      b_d = done_cyc.size(); b_bc = busy_cycles;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!dump_valid && n < 20) begin tick(); n++; end
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!switchRun && n < 200) begin tick(); n++; end
      checks++; if (switchRun !== 1'b1) begin failures++; $display("FAIL wrap_run_timeout%0d: got %b exp 1", s, switchRun); end
      start = 1'b1; tick(); start = 1'b0;
      wait_idle(100, "wrap");
      repeat (5) tick();
      model_count = (model_count + 1) % (1 << CW);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_extra_step%0d: busy got %b exp 0", s, busy); end
      checks++; if (done_cyc.size() - b_d != 1) begin failures++; $display("FAIL wrap_ndone%0d: got %0d exp 1", s, done_cyc.size() - b_d); end
      checks++; if (busy_cycles - b_bc != STEP_CYC) begin failures++; $display("FAIL wrap_busy_len%0d: got %0d exp %0d", s, busy_cycles - b_bc, STEP_CYC); end
      checks++; if (step_count !== CW'(model_count)) begin failures++; $display("FAIL wrap_count%0d: got %0d exp %0d", s, step_count, model_count); end
    end
    checks++; if (step_count !== '0) begin failures++; $display("FAIL wrap_final: got %0d exp 0", step_count); end
    checks++; if (done_cyc.size() - b_all != 4) begin failures++; $display("FAIL wrap_total_done: got %0d exp 4", done_cyc.size() - b_all); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_basic_step();
    test_backpressure();
    test_auto_halt();
    test_reset_mid_run();
    test_ignored_start_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
